// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: opcodes, instruction class codes, field positions, decoded control bundle.
// Pure declarations, no logic; imported by the decoder and its sub-modules.
package alu_pkg;

    localparam int CLASS_HI = 31;
    localparam int CLASS_LO = 26;
    localparam int RD_HI    = 25;
    localparam int RD_LO    = 21;
    localparam int RS_HI    = 20;
    localparam int RS_LO    = 16;
    localparam int RT_HI    = 15;
    localparam int RT_LO    = 11;
    localparam int FUNC_HI  = 3;
    localparam int FUNC_LO  = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_AND     = 4'b0010;
    localparam logic [3:0] OP_OR      = 4'b0011;
    localparam logic [3:0] OP_XOR     = 4'b0100;
    localparam logic [3:0] OP_NOR     = 4'b0101;
    localparam logic [3:0] OP_SLL     = 4'b0110;
    localparam logic [3:0] OP_SRL     = 4'b0111;
    localparam logic [3:0] OP_SRA     = 4'b1000;
    localparam logic [3:0] OP_ROL     = 4'b1001;
    localparam logic [3:0] OP_ROR     = 4'b1010;
    localparam logic [3:0] OP_SLTU    = 4'b1011;
    localparam logic [3:0] OP_SLT     = 4'b1100;
    localparam logic [3:0] OP_MUL     = 4'b1101;
    localparam logic [3:0] OP_LUI     = 4'b1110;
    localparam logic [3:0] OP_HAMMING = 4'b1111;

    localparam logic [5:0] CLS_RTYPE = 6'd0;
    localparam logic [5:0] CLS_ADDI  = 6'd1;
    localparam logic [5:0] CLS_SUBI  = 6'd2;
    localparam logic [5:0] CLS_ANDI  = 6'd3;
    localparam logic [5:0] CLS_ORI   = 6'd4;
    localparam logic [5:0] CLS_XORI  = 6'd5;
    localparam logic [5:0] CLS_SLTI  = 6'd6;
    localparam logic [5:0] CLS_LUI   = 6'd7;

    // Immediate travels beside this struct so its width can follow XLEN.
    typedef struct packed {
        logic [3:0] alu_op;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_imm;
        logic       wr_en;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_issue_decoder_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer (main + skid register) for a W-bit payload.
// Latency: 1 cycle accept to out_valid; full throughput with out_ready held high.
// Backpressure: second word parks in skid, registered in_ready drops until skid drains.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {EMPTY, MAIN, SKID} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] main_q, skid_q;
    logic         accept;
    logic         load_main, load_skid, main_from_skid;

    assign accept    = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = MAIN;
                    load_main = 1'b1;
                end
            end
            MAIN: begin
                if (accept && out_ready) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_nxt = SKID;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            SKID: begin
                if (out_ready) begin
                    state_nxt      = MAIN;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != SKID);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_from_skid) main_q <= skid_q;
            else if (load_main) main_q <= in_data;
            if (load_skid) skid_q <= in_data;
        end
    end

endmodule

// File: rtl/alu_issue_decoder.sv
// Decode/issue stage: 32-bit instruction -> registered ALU opcode, register indices, immediate, controls.
// Latency: 1 cycle accept to out_valid; streams 1 word/cycle while out_ready is high.
// Backpressure: 2-entry skid buffer; illegal-word counter enabled by ALU_ISSUE_ILLEGAL_CNT_EN.
module alu_issue_decoder
    import alu_pkg::*;
#(
    parameter int XLEN  = 32
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_use_imm,
    output logic            out_wr_en,
    output logic            out_illegal
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    localparam int PW = $bits(ctrl_t) + XLEN;

    ctrl_t            dec_ctrl, out_ctrl;
    logic [XLEN-1:0]  dec_imm;
    logic [5:0]       cls;
    logic [15:0]      imm16;
    logic [XLEN-1:0]  imm_sext, imm_zext;
    logic             i_type;

    assign cls      = in_instr[CLASS_HI:CLASS_LO];
    assign imm16    = in_instr[IMM_HI:IMM_LO];
    assign imm_sext = {{(XLEN-16){imm16[15]}}, imm16};
    assign imm_zext = {{(XLEN-16){1'b0}}, imm16};
    assign i_type   = (cls >= CLS_ADDI) && (cls <= CLS_LUI);

    always_comb begin
        dec_ctrl    = '0;
        dec_imm     = '0;
        dec_ctrl.rd = in_instr[RD_HI:RD_LO];
        dec_ctrl.rs = in_instr[RS_HI:RS_LO];
        dec_ctrl.rt = in_instr[RT_HI:RT_LO];
        case (cls)
            CLS_RTYPE: dec_ctrl.alu_op = in_instr[FUNC_HI:FUNC_LO];
            CLS_ADDI:  begin dec_ctrl.alu_op = OP_ADD; dec_imm = imm_sext; end
            CLS_SUBI:  begin dec_ctrl.alu_op = OP_SUB; dec_imm = imm_sext; end
            CLS_ANDI:  begin dec_ctrl.alu_op = OP_AND; dec_imm = imm_zext; end
            CLS_ORI:   begin dec_ctrl.alu_op = OP_OR;  dec_imm = imm_zext; end
            CLS_XORI:  begin dec_ctrl.alu_op = OP_XOR; dec_imm = imm_zext; end
            CLS_SLTI:  begin dec_ctrl.alu_op = OP_SLT; dec_imm = imm_sext; end
            // The ALU does the upper shift, so LUI carries the raw zero-extended field.
            CLS_LUI:   begin dec_ctrl.alu_op = OP_LUI; dec_imm = imm_zext; end
            default:   dec_ctrl.illegal = 1'b1;
        endcase
        if (i_type) begin
            dec_ctrl.use_imm = 1'b1;
            dec_ctrl.rt      = '0;
        end
        dec_ctrl.wr_en = !dec_ctrl.illegal && (dec_ctrl.rd != 5'd0);
    end

    logic [PW-1:0] out_payload;

    skid_buffer #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({dec_ctrl, dec_imm}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {out_ctrl, out_imm} = out_payload;
    assign out_alu_op  = out_ctrl.alu_op;
    assign out_rd      = out_ctrl.rd;
    assign out_rs      = out_ctrl.rs;
    assign out_rt      = out_ctrl.rt;
    assign out_use_imm = out_ctrl.use_imm;
    assign out_wr_en   = out_ctrl.wr_en;
    assign out_illegal = out_ctrl.illegal;

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (in_valid && in_ready && dec_ctrl.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Scoreboard bench for alu_issue_decoder: accepted words are modelled into a queue, a monitor pops on each output transfer.
module tb_alu_issue_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rd, out_rs, out_rt;
    logic [31:0] out_imm;
    logic        out_use_imm, out_wr_en, out_illegal;
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    alu_issue_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_op  (out_alu_op),
        .out_rd      (out_rd),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_imm     (out_imm),
        .out_use_imm (out_use_imm),
        .out_wr_en   (out_wr_en),
        .out_illegal (out_illegal)
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic        use_imm;
        logic        wr_en;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;
    int   delivered = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table of I-type opcodes and extension kinds indexed by class.
    function automatic exp_t model(input logic [31:0] w);
        logic [3:0] op_tbl [8];
        bit         sext_tbl [8];
        int         cls;
        exp_t       e;
        op_tbl   = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC, 4'hE};
        sext_tbl = '{0, 1, 1, 0, 0, 0, 1, 0};
        cls = int'(w[31:26]);
        e = '0;
        e.rd = w[25:21];
        e.rs = w[20:16];
        e.rt = w[15:11];
        if (cls == 0) begin
            e.alu_op = w[3:0];
        end else if (cls <= 7) begin
            e.alu_op  = op_tbl[cls];
            e.use_imm = 1'b1;
            e.rt      = 5'd0;
            e.imm     = sext_tbl[cls] ? 32'($signed(w[15:0])) : 32'(w[15:0]);
        end else begin
            e.illegal = 1'b1;
        end
        e.wr_en = !e.illegal && (e.rd != 0);
        return e;
    endfunction

    // Input side: every accepted word queues its expected bundle.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_cnt = 0;
        end else begin
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
            chk("illegal_cnt", 64'(illegal_cnt), 64'(model_cnt));
`endif
            if (in_valid && in_ready) begin
                exp_t m;
                m = model(in_instr);
                sb.push_back(m);
                accepts++;
                if (m.illegal && model_cnt != 16'hFFFF) model_cnt++;
            end
        end
    end

    // Output side: pop and compare on every output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(out_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bundle", 64'({out_alu_op, out_rd, out_rs, out_rt, out_imm,
                                   out_use_imm, out_wr_en, out_illegal}), 64'(e));
                delivered++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        bit done = 0;
        in_instr = w;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accept", 64'(done), 64'(1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  cls;
        r   = $urandom;
        cls = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 7));
        r[31:26] = cls;
        if ($urandom_range(0, 4) == 0) r[25:21] = 5'd0;
        return r;
    endfunction

    initial begin
        int d0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_data", 64'({out_alu_op, out_rd, out_rs, out_rt, out_imm,
                                 out_use_imm, out_wr_en, out_illegal}), 64'(0));
        #10 rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        send(32'h0461FFFF);
        chk("addi_latency_valid", 64'(out_valid), 64'(1));
        chk("addi_op", 64'(out_alu_op), 64'(4'b0000));
        chk("addi_rd_rs", 64'({out_rd, out_rs}), 64'({5'd3, 5'd1}));
        chk("addi_imm", 64'(out_imm), 64'(32'hFFFFFFFF));
        chk("addi_ctl", 64'({out_use_imm, out_wr_en}), 64'(2'b11));
        send(32'h00432001);
        chk("rsub_op", 64'(out_alu_op), 64'(4'b0001));
        chk("rsub_rt", 64'(out_rt), 64'(5'd4));
        chk("rsub_ctl", 64'({out_use_imm, out_wr_en}), 64'(2'b01));
        send(32'h1CA01234);
        chk("lui_op", 64'(out_alu_op), 64'(4'b1110));
        chk("lui_imm", 64'(out_imm), 64'(32'h00001234));
        chk("lui_wr", 64'(out_wr_en), 64'(1));
        send(32'hFC000000);
        chk("ill_flags", 64'({out_illegal, out_wr_en, out_alu_op}), 64'({1'b1, 1'b0, 4'b0000}));
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        chk("ill_cnt_first", 64'(illegal_cnt), 64'(1));
`endif
        wait_drain();

        // Backpressure: two accepts fill main+skid, then in_ready must drop.
        out_ready = 1'b0;
        d0 = delivered;
        send(32'h04210001);
        send(32'h00A41802);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        tick(); tick(); tick();
        chk("bp_hold_ready", 64'(in_ready), 64'(0));
        chk("bp_hold_rd", 64'(out_rd), 64'(5'd1));
        out_ready = 1'b1;
        send(32'h0C63F00F);
        send(32'hFFFFFFFF);
        wait_drain();
        chk("bp_delivered", 64'(delivered - d0), 64'(4));

        // Randomized traffic with random backpressure.
        in_instr = rand_instr();
        in_valid = 1'b1;
        for (int c = 0; c < 600; c++) begin
            bit acc;
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc || !in_valid) begin
                in_instr = rand_instr();
                in_valid = ($urandom_range(0, 2) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        chk("accept_equals_delivered", 64'(delivered), 64'(accepts));

        // Reset while in SKID drops both bundles.
        out_ready = 1'b0;
        send(32'h04410005);
        send(32'hF8000000);
        chk("skid_state", 64'(in_ready), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        tick();
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("post_rst_quiet", 64'(out_valid), 64'(0));
        end
        chk("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
